lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store sequencer between the decode/execute stage and the data-memory bus.
- Accepts one load or store per request, driven by the decoder's load/store, write-enable and access-width (func3) outputs plus the ALU-computed address.
- Generates byte lanes, stalls the core until the bus acknowledges, and returns sign- or zero-extended load data.
- Terminates hung transactions with a timeout error.

Parameters:
- TIMEOUT_CYCLES, 16: BUSY cycles without ack before abort; 0 disables the timeout.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  load/store request (decoder d_mem_load_store)
- req_we_i  in  1  1 = store, 0 = load
- req_width_i  in  3  func3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data (rs2)
- stall_o  out  1  hold the pipeline
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle error pulse (with done_o)
- rdata_o  out  32  extended load result, valid with done_o
- dmem_addr_o  out  32  word-aligned bus address
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_sel_o  out  4  byte enables
- dmem_we_o  out  1  bus write
- dmem_stb_o  out  1  bus request
- dmem_ack_i  in  1  bus acknowledge
- dmem_rdata_i  in  32  bus read data

Behaviour:

Reset:
- State IDLE.
- All registered outputs are 0: dmem_*, rdata_o, done_o, err_o, timeout counter.
- Reset asserted mid-transaction aborts immediately: stb drops asynchronously; no done_o is produced.

FSM:
- IDLE:
  - On req_valid_i, latch the request and go to BUSY with dmem_stb_o=1 on the next edge.
  - An illegal width (011, 110, 111) goes to RESP with err_o=1 and no bus cycle.
- BUSY:
  - Hold dmem_stb, addr, sel, we, wdata stable until dmem_ack_i.
  - On ack: stb=0, capture the extended read data (stores yield rdata_o=0), go to RESP.
  - Counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES (nonzero), drop stb, set err_o=1, rdata_o=0, go to RESP.
- RESP:
  - done_o=1 (err_o as set) for exactly one cycle, then go to IDLE.
  - req_valid_i is ignored in RESP.

Stall and latency:
- stall_o = (IDLE & req_valid_i) | BUSY; combinational; 0 in RESP.
- Minimum latency with ack in the first BUSY cycle: request cycle → BUSY → RESP = 3 cycles from request to done_o.
- A late ack arriving in IDLE or RESP is ignored.

Lanes and data (a = addr[1:0]):
- dmem_addr_o = {addr[31:2], 2'b00}.
- Byte: sel = 4'b0001 << a; wdata = {4{wdata[7:0]}}.
- Half: sel = a[1] ? 4'b1100 : 4'b0011; wdata = {2{wdata[15:0]}}.
- Word: sel = 4'b1111; wdata unchanged.
- Load: shift dmem_rdata_i right by 8*a.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Loads drive dmem_we_o=0 and still drive dmem_sel_o.

Optional Feature:
Macro LSU_MISALIGN_TRAP_EN:
- Defined: a misaligned access (half with a[0]=1, word with a≠0) in IDLE skips the bus and goes to RESP with err_o=1, rdata_o=0.
- Undefined: no misalign check.
  - Half uses a[1] only (a[0] ignored).
  - Word ignores a entirely (accesses the aligned word; no shift).

Test Plan:
- LW 0x100, ack in 3rd BUSY cycle, rdata 0xDEADBEEF → stb high 3 cycles, sel 1111, we 0, done_o pulse, rdata_o 0xDEADBEEF, no err.
- LB 0x103, bus rdata 0x80123456 → sel 1000, rdata_o 0xFFFFFF80. Same with LBU → 0x00000080. LHU 0x102 → 0x00008012.
- SH 0x202, wdata 0x1234ABCD → addr 0x200, sel 1100, wdata 0xABCDABCD, we 1; done_o after ack, rdata_o 0.
- LW 0x101: with LSU_MISALIGN_TRAP_EN → no stb, done_o+err_o pulse 2 cycles after request. Without it → bus read at 0x100, sel 1111.
- TIMEOUT_CYCLES=4, no ack → stb drops after 4 BUSY cycles, done_o+err_o pulse, rdata_o 0, FSM back in IDLE; a later ack is ignored.
- rst_ni low during BUSY → dmem_stb_o 0 same cycle (async). After release: IDLE, stall_o 0 until the next req_valid_i.

Source files
------------

// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between lsu_ctrl (master) and the memory/bus fabric (slave).
// Handshake: the master raises dmem_stb_o and holds addr/sel/we/wdata stable until
// the slave returns dmem_ack_i for one cycle; ack is only meaningful while stb is high.
interface lsu_ctrl_if;
  logic [31:0] dmem_addr_o;
  logic [31:0] dmem_wdata_o;
  logic [3:0]  dmem_sel_o;
  logic        dmem_we_o;
  logic        dmem_stb_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;

  modport master (
    output dmem_addr_o, dmem_wdata_o, dmem_sel_o, dmem_we_o, dmem_stb_o,
    input  dmem_ack_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_addr_o, dmem_wdata_o, dmem_sel_o, dmem_we_o, dmem_stb_o,
    output dmem_ack_i, dmem_rdata_i
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: byte-lane generation, pipeline stall, load extension and bus timeout.
// Optional macro LSU_MISALIGN_TRAP_EN rejects misaligned half/word accesses without a bus cycle.
module lsu_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [2:0]  req_width_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] rdata_o,
    output logic [1:0]  state_dbg_o,
    lsu_ctrl_if.master  dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] CNT_LAST = CW'(LAST);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    width_q;
    logic [1:0]    off_q;

    logic [3:0]    sel_c;
    logic [31:0]   wdata_c;
    logic          legal_c;
    logic          misalign_c;
    logic [31:0]   shifted_c;
    logic [31:0]   load_c;

    assign stall_o     = ((state == IDLE) && req_valid_i) || (state == BUSY);
    assign state_dbg_o = state;

    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = req_wdata_i;
        case (req_width_i[1:0])
            2'b00: begin
                sel_c   = 4'b0001 << req_addr_i[1:0];
                wdata_c = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                sel_c   = req_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{req_wdata_i[15:0]}};
            end
            default: begin
                sel_c   = 4'b1111;
                wdata_c = req_wdata_i;
            end
        endcase
    end

    always_comb begin
        legal_c = (req_width_i == 3'b000) || (req_width_i == 3'b001) || (req_width_i == 3'b010) ||
                  (req_width_i == 3'b100) || (req_width_i == 3'b101);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_c = ((req_width_i[1:0] == 2'b01) && req_addr_i[0]) ||
                     ((req_width_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
`else
        misalign_c = 1'b0;
`endif
    end

    // Without the misalign trap, halves honour only a[1] and words never shift.
    always_comb begin
        shifted_c = dmem.dmem_rdata_i;
        load_c    = dmem.dmem_rdata_i;
        case (width_q[1:0])
            2'b00: begin
                shifted_c = dmem.dmem_rdata_i >> {off_q, 3'b000};
                load_c    = {{24{~width_q[2] & shifted_c[7]}}, shifted_c[7:0]};
            end
            2'b01: begin
                shifted_c = dmem.dmem_rdata_i >> {off_q[1], 4'b0000};
                load_c    = {{16{~width_q[2] & shifted_c[15]}}, shifted_c[15:0]};
            end
            default: begin
                shifted_c = dmem.dmem_rdata_i;
                load_c    = dmem.dmem_rdata_i;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state             <= IDLE;
            cnt               <= '0;
            width_q           <= 3'b000;
            off_q             <= 2'b00;
            done_o            <= 1'b0;
            err_o             <= 1'b0;
            rdata_o           <= 32'h0;
            dmem.dmem_addr_o  <= 32'h0;
            dmem.dmem_wdata_o <= 32'h0;
            dmem.dmem_sel_o   <= 4'b0000;
            dmem.dmem_we_o    <= 1'b0;
            dmem.dmem_stb_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        if (!legal_c || misalign_c) begin
                            state   <= RESP;
                            done_o  <= 1'b1;
                            err_o   <= 1'b1;
                            rdata_o <= 32'h0;
                        end else begin
                            state             <= BUSY;
                            cnt               <= '0;
                            width_q           <= req_width_i;
                            off_q             <= req_addr_i[1:0];
                            dmem.dmem_addr_o  <= {req_addr_i[31:2], 2'b00};
                            dmem.dmem_wdata_o <= wdata_c;
                            dmem.dmem_sel_o   <= sel_c;
                            dmem.dmem_we_o    <= req_we_i;
                            dmem.dmem_stb_o   <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (dmem.dmem_ack_i) begin
                        state           <= RESP;
                        dmem.dmem_stb_o <= 1'b0;
                        done_o          <= 1'b1;
                        err_o           <= 1'b0;
                        rdata_o         <= dmem.dmem_we_o ? 32'h0 : load_c;
                    end else if ((TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST)) begin
                        state           <= RESP;
                        dmem.dmem_stb_o <= 1'b0;
                        done_o          <= 1'b1;
                        err_o           <= 1'b1;
                        rdata_o         <= 32'h0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    err_o  <= 1'b0;
                end
                default: begin
                    state           <= IDLE;
                    dmem.dmem_stb_o <= 1'b0;
                    done_o          <= 1'b0;
                    err_o           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed plan scenarios plus randomized loads/stores
// compared against an arithmetic reference model with an expected-data queue.
module tb_lsu_ctrl;
  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_width;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [1:0]  state_dbg;

  lsu_ctrl_if bus ();

  lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_we_i    (req_we),
    .req_width_i (req_width),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .stall_o     (stall),
    .done_o      (done),
    .err_o       (err),
    .rdata_o     (rdata),
    .state_dbg_o (state_dbg),
    .dmem        (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // observations captured by the driver
  int          stb_cycles;
  int          latency;
  logic        done_seen;
  logic        obs_err;
  logic [31:0] obs_rdata;
  logic [31:0] obs_addr;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_sel;
  logic        obs_we;
  logic        obs_stall_req;
  logic        obs_stall_resp;
  logic        stall_bad;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] m_load(input logic [2:0] w, input logic [1:0] a, input logic [31:0] d);
    int off;
    logic [31:0] v;
    if (w[1:0] == 2'b00) off = a;
    else if (w[1:0] == 2'b01) off = (a >= 2) ? 2 : 0;
    else off = 0;
    v = d >> (8 * off);
    case (w)
      3'b000: begin v = v % 256; if (v >= 128) v = v + 32'hFFFFFF00; end
      3'b100: v = v % 256;
      3'b001: begin v = v % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
      3'b101: v = v % 65536;
      default: v = d;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_sel(input logic [2:0] w, input logic [1:0] a);
    if (w[1:0] == 2'b00) return 4'(1 << a);
    if (w[1:0] == 2'b01) return (a >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] w, input logic [31:0] d);
    logic [31:0] b, h;
    b = d % 256;
    h = d % 65536;
    if (w[1:0] == 2'b00) return b * 32'h01010101;
    if (w[1:0] == 2'b01) return h * 32'h00010001;
    return d;
  endfunction

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_width = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ack_after: BUSY cycle (1-based) in which ack is raised; 0 = never
  task automatic run_txn(input logic we, input logic [2:0] w, input logic [31:0] addr,
                         input logic [31:0] wd, input int ack_after, input logic [31:0] bus_rd);
    int cyc;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_width = w; req_addr = addr; req_wdata = wd;
    #1 obs_stall_req = stall;
    stb_cycles = 0; latency = 0; done_seen = 1'b0; obs_err = 1'b0; obs_rdata = 32'h0;
    obs_addr = 32'h0; obs_wdata = 32'h0; obs_sel = 4'h0; obs_we = 1'b0;
    obs_stall_resp = 1'b1; stall_bad = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 0;
    while (!done_seen && cyc < 40) begin
      cyc++;
      if (bus.dmem_stb_o) begin
        stb_cycles++;
        obs_addr = bus.dmem_addr_o; obs_wdata = bus.dmem_wdata_o;
        obs_sel = bus.dmem_sel_o; obs_we = bus.dmem_we_o;
        if (!stall) stall_bad = 1'b1;
        if (stb_cycles == ack_after) begin
          bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = bus_rd;
        end else begin
          bus.dmem_rdata_i = $urandom;
        end
      end
      if (done) begin
        done_seen = 1'b1; obs_err = err; obs_rdata = rdata;
        obs_stall_resp = stall; latency = cyc;
      end
      @(posedge clk); #1;
      bus.dmem_ack_i = 1'b0;
    end
  endtask

  // scenarios
  task automatic test_reset();
    checks++; if (bus.dmem_stb_o !== 1'b0) begin failures++; $display("FAIL reset_stb got=%b exp=0", bus.dmem_stb_o); end
    checks++; if ({done, err} !== 2'b00) begin failures++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    checks++; if ({bus.dmem_addr_o, bus.dmem_sel_o, bus.dmem_we_o} !== 37'h0) begin failures++;
      $display("FAIL reset_bus got=%h/%h/%b exp=0", bus.dmem_addr_o, bus.dmem_sel_o, bus.dmem_we_o); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
  endtask

  task automatic test_lw();
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 3, 32'hDEADBEEF);
    checks++; if (stb_cycles !== 3) begin failures++; $display("FAIL lw_stb_cycles got=%0d exp=3", stb_cycles); end
    checks++; if ({obs_sel, obs_we} !== 5'b11110) begin failures++; $display("FAIL lw_sel_we got=%b exp=11110", {obs_sel, obs_we}); end
    checks++; if (obs_addr !== 32'h100) begin failures++; $display("FAIL lw_addr got=%h exp=100", obs_addr); end
    checks++; if ({done_seen, obs_err} !== 2'b10) begin failures++; $display("FAIL lw_done_err got=%b exp=10", {done_seen, obs_err}); end
    checks++; if (obs_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", obs_rdata); end
    checks++; if (latency !== 4) begin failures++; $display("FAIL lw_latency got=%0d exp=4", latency); end
    checks++; if ({obs_stall_req, stall_bad, obs_stall_resp} !== 3'b100) begin failures++;
      $display("FAIL lw_stall got=%b exp=100", {obs_stall_req, stall_bad, obs_stall_resp}); end
  endtask

  task automatic test_load_ext();
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80123456);
    checks++; if (obs_sel !== 4'b1000) begin failures++; $display("FAIL lb_sel got=%b exp=1000", obs_sel); end
    checks++; if (obs_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", obs_rdata); end
    checks++; if (latency !== 2) begin failures++; $display("FAIL lb_latency got=%0d exp=2", latency); end
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80123456);
    checks++; if (obs_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", obs_rdata); end
    run_txn(1'b0, 3'b101, 32'h102, 32'h0, 2, 32'h80123456);
    checks++; if (obs_sel !== 4'b1100) begin failures++; $display("FAIL lhu_sel got=%b exp=1100", obs_sel); end
    checks++; if (obs_rdata !== 32'h00008012) begin failures++; $display("FAIL lhu_rdata got=%h exp=00008012", obs_rdata); end
    run_txn(1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80123456);
    checks++; if (obs_rdata !== 32'hFFFF8012) begin failures++; $display("FAIL lh_rdata got=%h exp=ffff8012", obs_rdata); end
  endtask

  task automatic test_store();
    run_txn(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 1, 32'h5A5A5A5A);
    checks++; if (obs_addr !== 32'h200) begin failures++; $display("FAIL sh_addr got=%h exp=200", obs_addr); end
    checks++; if ({obs_sel, obs_we} !== 5'b11001) begin failures++; $display("FAIL sh_sel_we got=%b exp=11001", {obs_sel, obs_we}); end
    checks++; if (obs_wdata !== 32'hABCDABCD) begin failures++; $display("FAIL sh_wdata got=%h exp=abcdabcd", obs_wdata); end
    checks++; if ({done_seen, obs_err, obs_rdata} !== {2'b10, 32'h0}) begin failures++;
      $display("FAIL sh_resp got=%b%b/%h exp=10/0", done_seen, obs_err, obs_rdata); end
  endtask

  task automatic test_misalign();
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h11223344);
`ifdef LSU_MISALIGN_TRAP_EN
    checks++; if (stb_cycles !== 0) begin failures++; $display("FAIL mis_stb got=%0d exp=0", stb_cycles); end
    checks++; if ({done_seen, obs_err, obs_rdata} !== {2'b11, 32'h0}) begin failures++;
      $display("FAIL mis_resp got=%b%b/%h exp=11/0", done_seen, obs_err, obs_rdata); end
    checks++; if (latency !== 1) begin failures++; $display("FAIL mis_latency got=%0d exp=1", latency); end
`else
    checks++; if (stb_cycles !== 1) begin failures++; $display("FAIL mis_stb got=%0d exp=1", stb_cycles); end
    checks++; if ({obs_addr, obs_sel} !== {32'h100, 4'hF}) begin failures++;
      $display("FAIL mis_bus got=%h/%b exp=100/1111", obs_addr, obs_sel); end
    checks++; if ({obs_err, obs_rdata} !== {1'b0, 32'h11223344}) begin failures++;
      $display("FAIL mis_rdata got=%b/%h exp=0/11223344", obs_err, obs_rdata); end
`endif
  endtask

  task automatic test_illegal();
    run_txn(1'b0, 3'b110, 32'h300, 32'h0, 1, 32'h0);
    checks++; if (stb_cycles !== 0) begin failures++; $display("FAIL illegal_stb got=%0d exp=0", stb_cycles); end
    checks++; if ({done_seen, obs_err} !== 2'b11) begin failures++; $display("FAIL illegal_err got=%b exp=11", {done_seen, obs_err}); end
    checks++; if (latency !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", latency); end
  endtask

  task automatic test_timeout();
    logic bad;
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 0, 32'h0);
    checks++; if (stb_cycles !== TO) begin failures++; $display("FAIL to_stb_cycles got=%0d exp=%0d", stb_cycles, TO); end
    checks++; if ({done_seen, obs_err, obs_rdata} !== {2'b11, 32'h0}) begin failures++;
      $display("FAIL to_resp got=%b%b/%h exp=11/0", done_seen, obs_err, obs_rdata); end
    checks++; if (latency !== TO + 1) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", latency, TO + 1); end
    // a late ack in IDLE must not produce anything
    bad = 1'b0;
    @(negedge clk); bus.dmem_ack_i = 1'b1; bus.dmem_rdata_i = 32'hFFFFFFFF;
    @(negedge clk); bus.dmem_ack_i = 1'b0;
    repeat (3) begin
      if (done || err || bus.dmem_stb_o || stall) bad = 1'b1;
      @(negedge clk);
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL late_ack got=activity exp=idle"); end
  endtask

  task automatic test_random();
    logic [2:0] widths [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [2:0] w;
    logic [31:0] a, d, brd, e;
    logic we;
    int ack_after;
    for (int i = 0; i < 30; i++) begin
      w = widths[$urandom_range(0, 4)];
      we = (w[2] == 1'b0) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = $urandom; d = $urandom; brd = $urandom;
`ifdef LSU_MISALIGN_TRAP_EN
      if (w[1:0] == 2'b01) a[0] = 1'b0;
      if (w[1:0] == 2'b10) a[1:0] = 2'b00;
`endif
      ack_after = $urandom_range(1, TO);
      exp_q.push_back(we ? 32'h0 : m_load(w, a[1:0], brd));
      run_txn(we, w, a, d, ack_after, brd);
      e = exp_q.pop_front();
      checks++; if ({done_seen, obs_err, obs_rdata} !== {2'b10, e}) begin failures++;
        $display("FAIL rnd_rdata[%0d] got=%b%b/%h exp=10/%h", i, done_seen, obs_err, obs_rdata, e); end
      checks++; if ({obs_addr, obs_sel, obs_we} !== {a & 32'hFFFFFFFC, m_sel(w, a[1:0]), we}) begin failures++;
        $display("FAIL rnd_bus[%0d] got=%h/%b/%b exp=%h/%b/%b", i, obs_addr, obs_sel, obs_we,
                 a & 32'hFFFFFFFC, m_sel(w, a[1:0]), we); end
      checks++; if (we && obs_wdata !== m_wdata(w, d)) begin failures++;
        $display("FAIL rnd_wdata[%0d] got=%h exp=%h", i, obs_wdata, m_wdata(w, d)); end
      checks++; if (latency !== ack_after + 1 || stb_cycles !== ack_after) begin failures++;
        $display("FAIL rnd_latency[%0d] got=%0d/%0d exp=%0d/%0d", i, latency, stb_cycles, ack_after + 1, ack_after); end
    end
  endtask

  task automatic test_reset_mid();
    logic bad;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_width = 3'b010; req_addr = 32'h500;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.dmem_stb_o !== 1'b1) begin failures++; $display("FAIL rstmid_pre_stb got=%b exp=1", bus.dmem_stb_o); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({bus.dmem_stb_o, stall, done} !== 3'b000) begin failures++;
      $display("FAIL rstmid_async got=%b exp=000", {bus.dmem_stb_o, stall, done}); end
    bad = 1'b0;
    repeat (2) begin @(negedge clk); if (done || bus.dmem_stb_o) bad = 1'b1; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (done || err || stall || bus.dmem_stb_o) bad = 1'b1; end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rstmid_idle got=activity exp=idle"); end
    run_txn(1'b0, 3'b010, 32'h600, 32'h0, 2, 32'hCAFEF00D);
    checks++; if ({done_seen, obs_err, obs_rdata} !== {2'b10, 32'hCAFEF00D}) begin failures++;
      $display("FAIL rstmid_after got=%b%b/%h exp=10/cafef00d", done_seen, obs_err, obs_rdata); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_misalign();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
